// File: rtl/count_ctrl_pkg.sv
// Shared types and defaults for the counter enable generator.
// Divider and debounce counter widths come from cnt_width.
package count_ctrl_pkg;

  typedef enum logic {
    ST_PAUSED  = 1'b0,
    ST_RUNNING = 1'b1
  } state_e;

  localparam int unsigned DEF_DIV0            = 1;
  localparam int unsigned DEF_DIV1            = 12_500_000;
  localparam int unsigned DEF_DIV2            = 25_000_000;
  localparam int unsigned DEF_DIV3            = 50_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;

  // Bits needed to count 0..max_count-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises and debounces one active-low pushbutton.
// Press is a registered one-cycle pulse on each accepted press.
module btn_debounce
  import count_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic Raw_n,
  output logic Level,
  output logic Press
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = Raw_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // A new level must persist for DEBOUNCE_CYCLES consecutive cycles.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Level = level_q;
  assign Press = press_q;

endmodule

// File: rtl/count_enable_gen.sv
// Generates the counter's En pulses at a switch-selected rate,
// with run/pause and single-step control from two pushbuttons.
module count_enable_gen
  import count_ctrl_pkg::*;
#(
  parameter int unsigned DIV0            = DEF_DIV0,
  parameter int unsigned DIV1            = DEF_DIV1,
  parameter int unsigned DIV2            = DEF_DIV2,
  parameter int unsigned DIV3            = DEF_DIV3,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [1:0] Speed,
  input  logic       RunBtn_n,
  input  logic       StepBtn_n,
  output logic       En,
  output logic       Running
);

  localparam int unsigned   DW      = cnt_width(DIV3);
  localparam logic [DW-1:0] RELOAD0 = DW'(DIV0 - 1);
  localparam logic [DW-1:0] RELOAD1 = DW'(DIV1 - 1);
  localparam logic [DW-1:0] RELOAD2 = DW'(DIV2 - 1);
  localparam logic [DW-1:0] RELOAD3 = DW'(DIV3 - 1);

  logic [1:0]    speed_s1_q, speed_s1_d;
  logic [1:0]    speed_s2_q, speed_s2_d;
  logic [1:0]    speed_prev_q, speed_prev_d;
  logic [DW-1:0] div_q, div_d;
  logic [DW-1:0] reload;
  state_e        state_q, state_d;
  logic          en_q, en_d;
  logic          run_press, step_press;
  logic          run_level, step_level;
  logic          levels_unused;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Raw_n  (RunBtn_n),
    .Level  (run_level),
    .Press  (run_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Raw_n  (StepBtn_n),
    .Level  (step_level),
    .Press  (step_press)
  );

  assign levels_unused = run_level ^ step_level;

  always_comb begin
    case (speed_s2_q)
      2'd0:    reload = RELOAD0;
      2'd1:    reload = RELOAD1;
      2'd2:    reload = RELOAD2;
      default: reload = RELOAD3;
    endcase
  end

  // Priority: run toggle, then speed change, then terminal count or step.
  always_comb begin
    speed_s1_d   = Speed;
    speed_s2_d   = speed_s1_q;
    speed_prev_d = speed_s2_q;
    state_d      = state_q;
    div_d        = div_q;
    en_d         = 1'b0;
    if (run_press) begin
      state_d = (state_q == ST_PAUSED) ? ST_RUNNING : ST_PAUSED;
      div_d   = reload;
    end else if (speed_s2_q != speed_prev_q) begin
      div_d = reload;
    end else if (state_q == ST_RUNNING) begin
      if (div_q == '0) begin
        en_d  = 1'b1;
        div_d = reload;
      end else begin
        div_d = div_q - DW'(1);
      end
    end else begin
      div_d = reload;
      en_d  = step_press;
    end
  end

  // The synchronised Speed resets to 3, so the divider starts at DIV3-1.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      speed_s1_q   <= 2'b11;
      speed_s2_q   <= 2'b11;
      speed_prev_q <= 2'b11;
      state_q      <= ST_PAUSED;
      div_q        <= RELOAD3;
      en_q         <= 1'b0;
    end else begin
      speed_s1_q   <= speed_s1_d;
      speed_s2_q   <= speed_s2_d;
      speed_prev_q <= speed_prev_d;
      state_q      <= state_d;
      div_q        <= div_d;
      en_q         <= en_d;
    end
  end

  assign En      = en_q;
  assign Running = (state_q == ST_RUNNING);

endmodule

// File: tb/tb_count_enable_gen.sv
// Scoreboard bench for count_enable_gen with small divider/debounce values.
// Inputs change just after the falling edge; outputs are sampled on it.
module tb_count_enable_gen;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [1:0] Speed;
  logic       RunBtn_n;
  logic       StepBtn_n;
  logic       En;
  logic       Running;

  typedef struct packed {
    logic en;
    logic run;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  count_enable_gen #(
    .DIV0(1), .DIV1(3), .DIV2(5), .DIV3(8), .DEBOUNCE_CYCLES(4)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Speed     (Speed),
    .RunBtn_n  (RunBtn_n),
    .StepBtn_n (StepBtn_n),
    .En        (En),
    .Running   (Running)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    exp_t e;
    Resetn = 1'b0; RunBtn_n = 1'b1; StepBtn_n = 1'b1; Speed = 2'd0;
    repeat (3) @(negedge Clock);
    n_checks++;
    if ({En, Running} !== 2'b00)
      $display("[TB] FAIL reset_state: En/Running=%b%b required=00", En, Running);
    else n_pass++;
    Resetn = 1'b1;
    for (int c = 0; c < 20; c++) sb_q.push_back('{en: 1'b0, run: 1'b0});
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      e = sb_q.pop_front();
      n_checks++;
      if ({En, Running} !== {e.en, e.run})
        $display("[TB] FAIL reset_idle c=%0d: En/Running=%b%b required=%b%b", c, En, Running, e.en, e.run);
      else n_pass++;
      if (c % 5 == 2) Speed = Speed + 2'd1;
    end
    Speed = 2'd1;
    repeat (6) @(negedge Clock);
  endtask

  task automatic test_run_speed1();
    exp_t e;
    int rise = -1;
    RunBtn_n = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(negedge Clock);
      if (rise < 0 && Running === 1'b1) begin
        rise = c;
        for (int k = 0; k < 24; k++)
          sb_q.push_back('{en: (k > 0 && k % 3 == 0), run: 1'b1});
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if ({En, Running} !== {e.en, e.run})
          $display("[TB] FAIL run_speed1 k=%0d: En/Running=%b%b required=%b%b", c - rise, En, Running, e.en, e.run);
        else n_pass++;
      end else if (rise < 0) begin
        n_checks++;
        if (En !== 1'b0)
          $display("[TB] FAIL run_wait_en c=%0d: En=%b required=0", c, En);
        else n_pass++;
      end
      if (c == 9) RunBtn_n = 1'b1;
    end
    n_checks++;
    if (rise < 0) $display("[TB] FAIL run_rise: Running never rose, rise=%0d required>=0", rise);
    else n_pass++;
    n_checks++;
    if (Running !== 1'b1) $display("[TB] FAIL run_after_release: Running=%b required=1", Running);
    else n_pass++;
    sb_q.delete();
  endtask

  task automatic test_bounce();
    logic pat[$];
    logic last;
    int   toggles;
    // Phase A: 2-cycle and 3-cycle glitches, both shorter than the debounce window.
    repeat (2) pat.push_back(1'b0);
    repeat (8) pat.push_back(1'b1);
    repeat (3) pat.push_back(1'b0);
    repeat (10) pat.push_back(1'b1);
    toggles = 0; last = Running;
    foreach (pat[i]) begin
      RunBtn_n = pat[i];
      @(negedge Clock);
      if (Running !== last) toggles++;
      last = Running;
    end
    n_checks++;
    if (toggles !== 0) $display("[TB] FAIL bounce_glitch: toggles=%0d required=0", toggles);
    else n_pass++;
    n_checks++;
    if (Running !== 1'b1) $display("[TB] FAIL bounce_glitch_state: Running=%b required=1", Running);
    else n_pass++;
    // Phase B: three bounces then a real 6-cycle hold.
    pat.delete();
    repeat (3) begin
      repeat (2) pat.push_back(1'b0);
      repeat (2) pat.push_back(1'b1);
    end
    repeat (6) pat.push_back(1'b0);
    repeat (14) pat.push_back(1'b1);
    toggles = 0; last = Running;
    foreach (pat[i]) begin
      RunBtn_n = pat[i];
      @(negedge Clock);
      if (Running !== last) toggles++;
      last = Running;
    end
    n_checks++;
    if (toggles !== 1) $display("[TB] FAIL bounce_hold: toggles=%0d required=1", toggles);
    else n_pass++;
    n_checks++;
    if (Running !== 1'b0) $display("[TB] FAIL bounce_hold_state: Running=%b required=0", Running);
    else n_pass++;
  endtask

  task automatic test_step();
    exp_t e;
    logic prev_en = 1'b0;
    int   pulses = 0;
    sb_q.delete();
    for (int p = 0; p < 4; p++) begin
      if (p < 3) begin
        sb_q.push_back('{en: 1'b1, run: 1'b0});
        StepBtn_n = 1'b0;
      end
      for (int c = 0; c < 12; c++) begin
        @(negedge Clock);
        if (En === 1'b1) begin
          n_checks++;
          if (prev_en !== 1'b0) $display("[TB] FAIL step_width: previous En=%b required=0", prev_en);
          else n_pass++;
          n_checks++;
          if (sb_q.size() == 0) begin
            $display("[TB] FAIL step_extra: En=%b with no step pending, required=0", En);
          end else begin
            e = sb_q.pop_front();
            if ({En, Running} !== {e.en, e.run})
              $display("[TB] FAIL step_pulse: En/Running=%b%b required=%b%b", En, Running, e.en, e.run);
            else begin
              n_pass++;
              pulses++;
            end
          end
        end
        prev_en = En;
        if (c == 5) StepBtn_n = 1'b1;
      end
    end
    n_checks++;
    if (pulses !== 3) $display("[TB] FAIL step_count: downstream count=%0d required=3", pulses);
    else n_pass++;
    n_checks++;
    if (Running !== 1'b0) $display("[TB] FAIL step_state: Running=%b required=0", Running);
    else n_pass++;
    sb_q.delete();
  endtask

  task automatic test_speed_change();
    exp_t e;
    int   rise = -1;
    int   fall = -1;
    int   k;
    logic prev_en = 1'b0;
    Speed = 2'd3;
    repeat (6) @(negedge Clock);
    RunBtn_n = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge Clock);
      if (rise < 0 && Running === 1'b1) begin
        rise = c;
        // En at 8 from the DIV3 count; the reload cycle swallows the would-be pulse at 16.
        for (int j = 0; j < 27; j++)
          sb_q.push_back('{en: (j == 8) || (j >= 17), run: 1'b1});
      end
      if (c == 5) RunBtn_n = 1'b1;
      if (rise >= 0) begin
        k = c - rise;
        e = sb_q.pop_front();
        n_checks++;
        if ({En, Running} !== {e.en, e.run})
          $display("[TB] FAIL speed_change k=%0d: En/Running=%b%b required=%b%b", k, En, Running, e.en, e.run);
        else n_pass++;
        if (k == 1) StepBtn_n = 1'b0;
        if (k == 7) StepBtn_n = 1'b1;
        if (k == 13) Speed = 2'd0;
        if (sb_q.size() == 0) break;
      end
    end
    n_checks++;
    if (rise < 0) $display("[TB] FAIL speed_rise: Running never rose, rise=%0d required>=0", rise);
    else n_pass++;
    // At DIV0=1 every running cycle is a terminal count, so the run press lands on one.
    RunBtn_n = 1'b0;
    prev_en = En;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clock);
      if (fall < 0 && Running === 1'b0) begin
        fall = c;
        n_checks++;
        if (prev_en !== 1'b1) $display("[TB] FAIL pause_prev_en: En=%b required=1", prev_en);
        else n_pass++;
        n_checks++;
        if (En !== 1'b0) $display("[TB] FAIL pause_tc_en: En=%b required=0", En);
        else n_pass++;
      end else if (fall >= 0) begin
        n_checks++;
        if ({En, Running} !== 2'b00)
          $display("[TB] FAIL pause_after c=%0d: En/Running=%b%b required=00", c, En, Running);
        else n_pass++;
      end
      prev_en = En;
      if (c == 5) RunBtn_n = 1'b1;
    end
    n_checks++;
    if (fall < 0) $display("[TB] FAIL pause_fall: Running never fell, fall=%0d required>=0", fall);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   rise = -1;
    RunBtn_n = 1'b0;
    for (int c = 0; c < 20 && rise < 0; c++) begin
      @(negedge Clock);
      if (c == 5) RunBtn_n = 1'b1;
      if (Running === 1'b1) rise = c;
    end
    RunBtn_n = 1'b1;
    n_checks++;
    if (rise < 0) $display("[TB] FAIL mid_rise: Running never rose, rise=%0d required>=0", rise);
    else n_pass++;
    repeat (8) @(negedge Clock);
    // Start a press that would be accepted if the reset did not discard it.
    RunBtn_n = 1'b0;
    repeat (2) @(negedge Clock);
    n_checks++;
    if ({En, Running} !== 2'b11)
      $display("[TB] FAIL pre_reset: En/Running=%b%b required=11", En, Running);
    else n_pass++;
    Resetn = 1'b0;
    @(negedge Clock);
    n_checks++;
    if ({En, Running} !== 2'b00)
      $display("[TB] FAIL reset_mid: En/Running=%b%b required=00", En, Running);
    else n_pass++;
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);
    RunBtn_n = 1'b1;
    for (int c = 0; c < 15; c++) sb_q.push_back('{en: 1'b0, run: 1'b0});
    for (int c = 0; c < 15; c++) begin
      @(negedge Clock);
      e = sb_q.pop_front();
      n_checks++;
      if ({En, Running} !== {e.en, e.run})
        $display("[TB] FAIL reset_discard c=%0d: En/Running=%b%b required=%b%b", c, En, Running, e.en, e.run);
      else n_pass++;
    end
  endtask

  initial begin
    Resetn = 1'b0; RunBtn_n = 1'b1; StepBtn_n = 1'b1; Speed = 2'd0;
    @(negedge Clock);
    $display("[TB] test_reset");
    test_reset();
    $display("[TB] test_run_speed1");
    test_run_speed1();
    $display("[TB] test_bounce");
    test_bounce();
    $display("[TB] test_step");
    test_step();
    $display("[TB] test_speed_change");
    test_speed_change();
    $display("[TB] test_reset_mid");
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/count_enable_gen.md
Name: count_enable_gen

Overview:
Upstream control stage for the lab 8-bit T-flip-flop counter. It generates that counter's En input as single-cycle enable pulses at a switch-selectable rate from the 50 MHz board clock. It also provides run/pause and single-step control from two debounced active-low pushbuttons. Its En output wires directly to the counter's En; both blocks share Clock and Resetn.

Parameters:
DIV0, 1, En period in clocks for Speed=0 (every cycle while running)
DIV1, 12_500_000, En period for Speed=1 (4 Hz at 50 MHz)
DIV2, 25_000_000, En period for Speed=2 (2 Hz)
DIV3, 50_000_000, En period for Speed=3 (1 Hz)
DEBOUNCE_CYCLES, 1_000_000, clocks a button must hold a new level before it is accepted (20 ms)

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  synchronous, active-low reset
Speed  input  2  rate select from slide switches; asynchronous, must be synchronised internally
RunBtn_n  input  1  raw pushbutton, low = pressed; each accepted press toggles run/pause
StepBtn_n  input  1  raw pushbutton, low = pressed; each accepted press issues one En while paused
En  output  1  one-cycle enable pulse to the counter
Running  output  1  high while in RUNNING state

Behaviour:
- Reset: clock Clock; reset Resetn, synchronous, active-low. On reset: En=0, Running=0, state=PAUSED, debounced levels=1 (released), all sync flops=1, divider loaded with DIV[Speed]-1, debounce counters=0.
- Input sync: two-flop synchroniser on RunBtn_n, StepBtn_n and each Speed bit.
- Debounce, per button:
  - The counter increments while the synchronised level differs from the debounced level, and clears when the levels match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are never accepted.
- Press event: one-cycle pulse, registered, on a debounced 1->0 transition. Release generates no event. A held button yields exactly one event.
- FSM, states PAUSED and RUNNING:
  - PAUSED -> RUNNING on a run event.
  - RUNNING -> PAUSED on a run event.
  - Running is the registered state bit.
- Divider:
  - Width is ceil(log2(DIV3)); all DIVn must be >= 1.
  - In RUNNING, it counts down each cycle. At 0, En=1 for that cycle and the divider reloads DIV[Speed]-1.
  - In PAUSED, it is held at DIV[Speed]-1.
  - On PAUSED->RUNNING, the first En occurs exactly DIV[Speed] cycles after Running rises. With DIV=1, En is high every cycle while Running=1.
- Speed change (synchronised value differs from the registered previous value): the divider reloads the new DIV-1 that cycle, and no En is issued that cycle.
- Step: a step event while PAUSED gives En=1 on the next cycle, for exactly one cycle. Step events while RUNNING are ignored.
- Priority, highest first: reset > run event > speed change > divider terminal count / step.
  - A run event coinciding with terminal count while RUNNING: pause, no En.
  - Run and step events in the same cycle: toggle only, no En.
- Mid-operation reset: reset asserted at any point returns everything to the reset values on the next edge. Any pulse or debounce in progress is discarded.
- En is registered (flop output) and never high for two consecutive cycles unless DIV[Speed]=1 and RUNNING.

Decomposition:
- Package count_ctrl_pkg holds:
  - state encodings ST_PAUSED=1'b0, ST_RUNNING=1'b1
  - default divider constants
  - a width function computing the divider width from DIV3
- Sub-module btn_debounce:
  - ports: Clock, Resetn, Raw_n, Level, Press
  - contains the synchroniser, debounce counter and falling-edge pulse
  - instanced twice, for RunBtn_n and StepBtn_n

Test Plan (bench parameters: DIV0=1, DIV1=3, DIV2=5, DIV3=8, DEBOUNCE_CYCLES=4):
1. Reset with buttons idle -> En=0 and Running=0 for 20 cycles; Speed changes produce no En.
2. Hold RunBtn_n low for 10 cycles with Speed=1 -> Running rises once. En pulses every 3rd cycle, with the first pulse 3 cycles after Running rises; releasing the button does not toggle state.
3. RunBtn_n low-pulse of 2 cycles (bounce) -> no state change. Three bounces followed by a 6-cycle hold -> exactly one toggle.
4. While PAUSED, press StepBtn_n three times (6-cycle holds separated by 6-cycle releases) -> exactly three single-cycle En pulses, so a downstream counter reads 3.
5. RUNNING at Speed=3: switch to Speed=0 mid-count -> no En on the reload cycle, then En high every cycle. A run press timed to land on a terminal count -> Running=0 and no En that cycle.
6. Assert Resetn=0 for 1 cycle mid-debounce and while RUNNING -> next cycle Running=0, En=0. The partially-debounced press is not accepted after Resetn returns high.
